// File: rtl/dlatch_pkg.sv
// Shared definitions for the D-latch consumer logic.
//   state_e               : debounce FSM state encoding
//   DefaultDebounceCycles : default qualification window length
package dlatch_pkg;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_e;

  localparam int unsigned DefaultDebounceCycles = 4;

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop-chain synchroniser with synchronous active-high reset to 0.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   d     : asynchronous input
//   q     : d delayed by STAGES clock edges
module sync_ff_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dlatch_sync_debounce.sv
// Synchronises and debounces the asynchronous D-latch output, producing a clean level,
// one-cycle rise/fall pulses and a wrapping count of accepted transitions.
// Ports:
//   clk      : clock, all state updates on posedge
//   reset    : synchronous active-high reset, highest priority
//   y_in     : asynchronous latch output
//   clr_cnt  : synchronous clear of edge_cnt, wins over a simultaneous increment
//   level    : debounced, synchronised value of y_in
//   rise     : one-cycle pulse on an accepted 0->1
//   fall     : one-cycle pulse on an accepted 1->0
//   busy     : a candidate transition is being qualified
//   edge_cnt : accepted transitions modulo 2^CNT_W
module dlatch_sync_debounce
  import dlatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  // cnt holds how many consecutive cycles ys has already shown the candidate; the cycle
  // that sees it with cnt == D-1 is the D-th one and completes qualification.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic ys;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (y_in),
    .q    (ys)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (ys) begin
          // A one-cycle window is satisfied by the very first sighting.
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = S_WAIT_H;
            cnt_d   = CntOne;
          end
        end
      end
      S_WAIT_H: begin
        if (!ys) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      S_HIGH: begin
        if (!ys) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = S_WAIT_L;
            cnt_d   = CntOne;
          end
        end
      end
      S_WAIT_L: begin
        if (ys) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase

    busy_d = (state_d == S_WAIT_H) || (state_d == S_WAIT_L);

    // Counted on the same edge the pulse is registered so clr_cnt can override it.
    if (clr_cnt) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + CNT_W'(rise_d | fall_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOW;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      busy_q     <= busy_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign busy     = busy_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_dlatch_sync_debounce.sv
module tb_dlatch_sync_debounce;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       y_in;
  logic       clr_cnt;
  logic       level, rise, fall, busy;
  logic [7:0] edge_cnt;
  logic       level_b, rise_b, fall_b, busy_b;
  logic [1:0] edge_cnt_b;

  always #5 clk = ~clk;

  dlatch_sync_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .y_in    (y_in),
    .clr_cnt (clr_cnt),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy),
    .edge_cnt(edge_cnt)
  );

  // Same stimulus, narrow counter to exercise wrap-around.
  dlatch_sync_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (2)
  ) u_dut_w2 (
    .clk     (clk),
    .reset   (reset),
    .y_in    (y_in),
    .clr_cnt (clr_cnt),
    .level   (level_b),
    .rise    (rise_b),
    .fall    (fall_b),
    .busy    (busy_b),
    .edge_cnt(edge_cnt_b)
  );

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Reference model: the value seen by the clocked logic is y_in from S edges ago; a level
  // is accepted once D consecutive seen values differ from the current level.
  bit m_pipe[S];
  bit m_level, m_rise, m_fall;
  int m_run, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic model_edge(input bit y, input bit r, input bit c);
    bit ys;
    if (r) begin
      m_level = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;
      for (int i = 0; i < S; i++) m_pipe[i] = 0;
    end else begin
      ys = m_pipe[S-1];
      m_rise = 0;
      m_fall = 0;
      if (ys != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = ys;
          m_rise  = ys;
          m_fall  = !ys;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      if (c) m_cnt = 0;
      else if (m_rise || m_fall) m_cnt++;
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = y;
    end
  endtask

  task automatic step(input logic y, input logic r, input logic c);
    y_in    = y;
    reset   = r;
    clr_cnt = c;
    @(posedge clk);
    edge_no++;
    model_edge(y, r, c);
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("busy", 32'(busy), 32'(m_run > 0));
    chk("edge_cnt", 32'(edge_cnt), 32'(m_cnt % 256));
    chk("edge_cnt_w2", 32'(edge_cnt_b), 32'(m_cnt % 4));
    chk("level_w2", 32'(level_b), 32'(m_level));
  endtask

  // Drive a steady value long enough for it to be accepted; count pulses seen.
  int n_rise, n_fall;
  task automatic hold(input logic v, input int n);
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < n; i++) begin
      step(v, 1'b0, 1'b0);
      if (rise) n_rise++;
      if (fall) n_fall++;
    end
  endtask

  initial begin
    int   rise_edge;
    bit   saw_busy, saw_rise;
    logic [1:0] wrap_exp [5];
    int   hold_len;
    logic yv;

    y_in = 0; reset = 1; clr_cnt = 0;
    for (int i = 0; i < S; i++) m_pipe[i] = 0;
    m_level = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;

    // Reset held three cycles with y_in high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);

    // Clean rise: y_in high from edge 10, rise expected right after edge 10+S+D-1 = 15.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    rise_edge = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (rise) rise_edge = edge_no;
    end
    chk("t2_rise_edge", 32'(rise_edge), 32'd15);
    chk("t2_level", 32'(level), 32'd1);
    chk("t2_edge_cnt", 32'(edge_cnt), 32'd1);

    // Glitch shorter than the window is rejected.
    hold(1'b0, 10);
    saw_busy = 0;
    saw_rise = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      saw_busy |= busy;
      saw_rise |= rise;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      saw_busy |= busy;
      saw_rise |= rise;
    end
    chk("t3_busy_seen", 32'(saw_busy), 32'd1);
    chk("t3_no_rise", 32'(saw_rise), 32'd0);
    chk("t3_level", 32'(level), 32'd0);
    chk("t3_edge_cnt", 32'(edge_cnt), 32'd2);

    // Wrap on the 2-bit counter over five clean toggles.
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hold((i % 2 == 0) ? 1'b1 : 1'b0, 8);
      chk("t4_wrap_cnt", 32'(edge_cnt_b), 32'(wrap_exp[i]));
      chk("t4_rise_n", 32'(n_rise), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t4_fall_n", 32'(n_fall), (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // clr_cnt on the acceptance edge of a fall with edge_cnt at 3.
    hold(1'b0, 8);
    step(1'b0, 1'b0, 1'b1);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    chk("t5_pre_cnt", 32'(edge_cnt), 32'd3);
    for (int i = 0; i < S + D - 1; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_fall", 32'(fall), 32'd1);
    chk("t5_cnt", 32'(edge_cnt), 32'd0);
    chk("t5_cnt_w2", 32'(edge_cnt_b), 32'd0);
    hold(1'b0, 4);

    // Reset during qualification, then acceptance restarts from reset release.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_level_rst", 32'(level), 32'd0);
    rise_edge = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (rise && rise_edge < 0) rise_edge = i;
    end
    chk("t6_rise_after_release", 32'(rise_edge), 32'(S + D));

    // Randomised bursts with occasional clears and resets.
    hold_len = 0;
    yv = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_len == 0) begin
        yv       = 1'($urandom_range(0, 1));
        hold_len = int'($urandom_range(1, 9));
      end
      hold_len--;
      step(yv, 1'($urandom_range(0, 127) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
